// File: rtl/pixel_readout_ctrl.sv
// Frame controller for the pixel array: erase, expose, convert, then per-row settle/capture
// and a valid/ready pixel stream (one beat per accepted cycle, column 0 first).
module pixel_readout_ctrl #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int DW        = 8,
    parameter int EXP_W     = 16,
    parameter int C_ERASE   = 5,
    parameter int C_CONVERT = 255,
    parameter int C_SETTLE  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EXP_W-1:0]     exp_cycles,
    input  logic [COLS*DW-1:0]   col_data,
    output logic                 erase,
    output logic                 expose,
    output logic                 convert,
    output logic [ROWS-1:0]      read,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    // Handshake: a beat transfers on a clock edge where out_valid & out_ready are both high;
    // while out_valid is high and out_ready low, out_data and the sof/eol/eof flags hold.

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CW  = max2(EXP_W, max2($clog2(C_CONVERT + 1),
                         max2($clog2(C_ERASE + 1), $clog2(C_SETTLE + 1))));
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_SETTLE  = 3'd4,
        S_STREAM  = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [EXP_W-1:0]    exp_len, exp_len_n;
    logic [RW-1:0]       row, row_n;
    logic [CLW-1:0]      col, col_n;
    logic [COLS*DW-1:0]  shadow, shadow_n;
    logic                strm_n;

    assign dbg_state = state;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        exp_len_n = exp_len;
        row_n     = row;
        col_n     = col;
        shadow_n  = shadow;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_ERASE;
                    cnt_n     = '0;
                    row_n     = '0;
                    col_n     = '0;
                    exp_len_n = (exp_cycles == '0) ? EXP_W'(1) : exp_cycles;
                end
            end
            S_ERASE: begin
                if (cnt == CW'(C_ERASE - 1)) begin
                    state_n = S_EXPOSE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_EXPOSE: begin
                if (cnt == CW'(exp_len) - CW'(1)) begin
                    state_n = S_CONVERT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_CONVERT: begin
                if (cnt == CW'(C_CONVERT - 1)) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(C_SETTLE - 1)) begin
                    state_n  = S_STREAM;
                    cnt_n    = '0;
                    col_n    = '0;
                    shadow_n = col_data;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STREAM: begin
                if (out_valid && out_ready) begin
                    if (col == CLW'(COLS - 1)) begin
                        col_n = '0;
                        if (row == RW'(ROWS - 1)) begin
                            state_n = S_IDLE;
                            row_n   = '0;
                        end else begin
                            state_n = S_SETTLE;
                            row_n   = row + RW'(1);
                            cnt_n   = '0;
                        end
                    end else begin
                        col_n = col + CLW'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                row_n   = '0;
                col_n   = '0;
            end
        endcase
        // Abort wins over everything in the same cycle, including a start seen in IDLE.
        if (abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            row_n   = '0;
            col_n   = '0;
        end
        strm_n = (state_n == S_STREAM);
    end

    // Outputs are registered copies of what the next state implies, so they change with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            exp_len   <= '0;
            row       <= '0;
            col       <= '0;
            shadow    <= '0;
            erase     <= 1'b0;
            expose    <= 1'b0;
            convert   <= 1'b0;
            read      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            exp_len   <= exp_len_n;
            row       <= row_n;
            col       <= col_n;
            shadow    <= shadow_n;
            erase     <= (state_n == S_ERASE);
            expose    <= (state_n == S_EXPOSE);
            convert   <= (state_n == S_CONVERT);
            read      <= (state_n == S_SETTLE || strm_n) ? (ROWS'(1) << row_n) : '0;
            out_data  <= strm_n ? shadow_n[int'(col_n)*DW +: DW] : '0;
            out_valid <= strm_n;
            out_sof   <= strm_n && (row_n == '0) && (col_n == '0);
            out_eol   <= strm_n && (col_n == CLW'(COLS - 1));
            out_eof   <= strm_n && (col_n == CLW'(COLS - 1)) && (row_n == RW'(ROWS - 1));
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule
